modexp_ctrl: RTL and testbench

MODEXP_CTRL -- requirements
Module: modexp_ctrl

---
 rtl/modexp_ctrl.sv | 104 ++++++++++
 tb/tb_modexp_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/modexp_ctrl.sv
// modexp_ctrl: left-to-right square-and-multiply controller for base^exponent mod modulus
// Ports: clk, reset_l (async, active-low); start/base/exponent/modulus request a computation;
// busy/done/result report it; mul_start/mul_a/mul_b/mul_n issue modular multiplies to an
// external multiplier that answers with mul_valid/mul_result.
module modexp_ctrl #(
  parameter int WIDTH = 5,
  parameter int EXP_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic [WIDTH-1:0]     mul_n,
  input  logic                 mul_valid,
  input  logic [WIDTH-1:0]     mul_result
);
  localparam int IW = EXP_WIDTH > 1 ? $clog2(EXP_WIDTH) : 1;
  localparam logic [IW-1:0] TOP = IW'(EXP_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, REDUCE, SCAN, SQR_REQ, SQR_WAIT, MUL_REQ, MUL_WAIT, FINISH} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] b_reg, n_reg, r, res_q;
  logic [EXP_WIDTH-1:0] e_reg;
  logic [IW-1:0] i;
  logic seen, small_n, last, sqr, act;
  assign small_n = (n_reg[WIDTH-1:1] == '0);
  assign last = (i == '0);
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = start ? REDUCE : IDLE;
      REDUCE:   nxt = small_n ? FINISH : (b_reg >= n_reg ? REDUCE : SCAN);
      SCAN:     nxt = seen ? SQR_REQ : (last ? FINISH : SCAN);
      SQR_REQ:  nxt = SQR_WAIT;
      SQR_WAIT: nxt = !mul_valid ? SQR_WAIT : (e_reg[i] ? MUL_REQ : (last ? FINISH : SCAN));
      MUL_REQ:  nxt = MUL_WAIT;
      MUL_WAIT: nxt = !mul_valid ? MUL_WAIT : (last ? FINISH : SCAN);
      default:  nxt = IDLE;
    endcase
  end
  always_comb begin
    sqr = state == SQR_REQ || state == SQR_WAIT;
    act = sqr || state == MUL_REQ || state == MUL_WAIT;
    busy = state != IDLE && state != FINISH;
    done = state == FINISH;
    result = state == FINISH ? r : res_q;
    mul_start = state == SQR_REQ || state == MUL_REQ;
    mul_a = act ? r : '0;
    mul_b = act ? (sqr ? r : b_reg) : '0;
    mul_n = act ? n_reg : '0;
  end
  // r starts at 1 so an all-zero exponent yields 1; the first one bit loads r with the
  // reduced base instead of squaring 1, which keeps the multiply count minimal.
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) begin
      b_reg <= '0;
      n_reg <= '0;
      e_reg <= '0;
      r <= '0;
      res_q <= '0;
      i <= '0;
      seen <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          b_reg <= base;
          e_reg <= exponent;
          n_reg <= modulus;
          r <= WIDTH'(1);
          i <= TOP;
          seen <= 1'b0;
        end
        REDUCE: if (small_n) r <= '0;
        else if (b_reg >= n_reg) b_reg <= b_reg - n_reg;
        SCAN: if (!seen) begin
          if (e_reg[i]) begin
            r <= b_reg;
            seen <= 1'b1;
          end
          if (!last) i <= i - IW'(1);
        end
        SQR_WAIT: if (mul_valid) begin
          r <= mul_result;
          if (!e_reg[i] && !last) i <= i - IW'(1);
        end
        MUL_WAIT: if (mul_valid) begin
          r <= mul_result;
          if (!last) i <= i - IW'(1);
        end
        FINISH: res_q <= r;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_modexp_ctrl.sv
// tb_modexp_ctrl: directed and random checks of modexp_ctrl against a behavioural multiplier
module tb_modexp_ctrl;
  logic clk = 1'b0;
  logic reset_l = 1'b0;
  logic start = 1'b0;
  logic [4:0] base = '0, exponent = '0, modulus = '0;
  logic busy, done, mul_start, mul_valid;
  logic [4:0] result, mul_a, mul_b, mul_n, mul_result;
  int errors = 0, checks = 0;
  int exp_q[$];
  int mul_count = 0, mul_lat = 1;
  bit rand_lat = 0, spur_req = 0;

  modexp_ctrl dut (
    .clk(clk), .reset_l(reset_l), .start(start), .base(base), .exponent(exponent),
    .modulus(modulus), .busy(busy), .done(done), .result(result), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b), .mul_n(mul_n), .mul_valid(mul_valid), .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int gold(int b, int e, int n);
    int r = 1;
    if (n <= 1) return 0;
    for (int k = 4; k >= 0; k--) begin
      r = (r * r) % n;
      if (e[k]) r = (r * b) % n;
    end
    return r;
  endfunction

  function automatic int mcount(int e, int n);
    int p = -1;
    int c;
    if (n <= 1) return 0;
    for (int k = 0; k < 5; k++) if (e[k]) p = k;
    if (p < 0) return 0;
    c = p;
    for (int k = 0; k < p; k++) c += e[k];
    return c;
  endfunction

  // Behavioural multiplier: captures operands on mul_start, answers after the chosen latency.
  initial begin
    bit pend = 0, stale = 1;
    int cnt = 0;
    logic [4:0] pa = '0, pb = '0, pn = '0;
    mul_valid = 1'b0;
    mul_result = '0;
    forever begin
      @(posedge clk);
      #1;
      mul_valid = 1'b0;
      if (!reset_l) stale = 1;
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          pend = 0;
          if (!stale) begin
            check("mul_a_stable", mul_a, pa);
            check("mul_b_stable", mul_b, pb);
            check("mul_n_stable", mul_n, pn);
          end
          mul_valid = 1'b1;
          mul_result = pn == 0 ? 5'd0 : 5'((int'(pa) * int'(pb)) % int'(pn));
        end
      end else if (spur_req) begin
        spur_req = 0;
        mul_valid = 1'b1;
        mul_result = 5'd17;
      end
      if (mul_start) begin
        check("mul_overlap", pend, 0);
        mul_count++;
        pend = 1;
        stale = 0;
        pa = mul_a;
        pb = mul_b;
        pn = mul_n;
        cnt = rand_lat ? $urandom_range(1, 20) : mul_lat;
      end
    end
  end

  task automatic run_op(input int b, input int e, input int n, input int lat, input bit rl,
                        input bit noise, input string tag);
    int k = 0;
    int exp_r;
    @(negedge clk);
    base = 5'(b);
    exponent = 5'(e);
    modulus = 5'(n);
    mul_lat = lat;
    rand_lat = rl;
    mul_count = 0;
    start = 1'b1;
    exp_q.push_back(gold(b, e, n));
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    while (!done && k < 4000) begin
      @(negedge clk);
      k++;
      if (noise && k == 1) begin
        start = 1'b1;
        base = 5'd7;
        spur_req = 1;
      end else if (noise && k == 2) start = 1'b0;
    end
    exp_r = exp_q.pop_front();
    check({tag, "_done"}, done, 1);
    check({tag, "_result"}, result, exp_r);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_mul_count"}, mul_count, mcount(e, n));
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_result_held"}, result, exp_r);
  endtask

  initial begin
    int k;
    bit saw;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_n", mul_n, 0);
    repeat (2) @(negedge clk);
    reset_l = 1'b1;
    run_op(3, 5, 23, 5, 0, 0, "pow3_5_23");
    run_op(30, 2, 7, 2, 0, 0, "reduce30_7");
    run_op(4, 0, 9, 1, 0, 0, "exp0");
    run_op(4, 5, 1, 1, 0, 0, "mod1");
    run_op(6, 3, 0, 1, 0, 0, "mod0");
    run_op(5, 31, 31, 1, 0, 0, "exp31");
    run_op(31, 1, 2, 1, 0, 0, "exp1_mod2");
    run_op(3, 5, 23, 4, 0, 1, "noise");
    // Reset while the first squaring is outstanding.
    @(negedge clk);
    base = 5'd3;
    exponent = 5'd5;
    modulus = 5'd23;
    mul_lat = 10;
    rand_lat = 0;
    mul_count = 0;
    start = 1'b1;
    exp_q.push_back(13);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (mul_count == 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("rst_sqr_issued", mul_count, 1);
    @(negedge clk);
    reset_l = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_mul_start", mul_start, 0);
    check("mid_rst_mul_a", mul_a, 0);
    check("mid_rst_mul_b", mul_b, 0);
    check("mid_rst_mul_n", mul_n, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_l = 1'b1;
    saw = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) saw = 1;
    end
    check("post_rst_no_done", saw, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_result", result, 0);
    run_op(3, 5, 23, 3, 0, 0, "fresh");
    repeat (10) run_op($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 1, 1, 0, "rand");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
